serial_deserializer: RTL
========================

# serial_deserializer

Receive-side counterpart of the team's parallel-to-serial transmit block. It samples a single-bit asynchronous serial line framed as start bit (0), DATA_W data bits LSB first, an optional parity bit and a stop bit (1). It presents each received word on a parallel bus with a one-cycle valid strobe. It sits at the edge of the design, between an external pin and the byte-wide consumer logic.

## Interface
- CLKS_PER_BIT, 50, clock cycles per serial bit; even, ≥ 4
- DATA_W, 8, data bits per frame; 1..16
- clk  input  1  system clock, all flops on rising edge
- rst  input  1  reset, asynchronous and active-low (0 = reset)
- serial_in  input  1  asynchronous serial line, idles high
- data_out  output  DATA_W  last correctly framed word, held until the next good frame
- data_valid  output  1  one-cycle pulse when data_out is updated
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out
- busy  output  1  high whenever the state is not IDLE

## Operation
- The input passes through a 2-flop synchronizer and then a registered copy s_d. Both synchronizer flops and s_d reset to 1, so reset release produces no false edge.
- A start edge is s_d=1 and s=0.
- Bit counter cnt (clog2(CLKS_PER_BIT) bits) and bit index idx (clog2(DATA_W+1) bits).
- **IDLE:** on a start edge, go to START with cnt=0. A line held low never retriggers; a new frame needs high-to-low.
- **START:** cnt increments each cycle. When cnt==CLKS_PER_BIT/2−1, sample s.
  - s=0: go to DATA with cnt=0, idx=0.
  - s=1: treat as a glitch and return to IDLE with no pulses.
- **DATA:** when cnt==CLKS_PER_BIT−1, shift s into the MSB of the shift register (shift right), idx++, cnt=0.
  - After the sample with idx==DATA_W−1, go to PARITY if compiled in, else STOP.
- **PARITY:** sample at cnt==CLKS_PER_BIT−1 and compare with even parity of the data bits. Store the mismatch flag and go to STOP.
- **STOP:** sample at cnt==CLKS_PER_BIT−1, then go to IDLE.
  - s=1 and no parity mismatch: data_out ← shift register, data_valid=1.
  - s=1 and parity mismatch: parity_err=1, data_out unchanged.
  - s=0: frame_err=1 only (frame_err takes priority over parity_err), data_out unchanged.
- data_valid, frame_err and parity_err are mutually exclusive. Each is high for exactly one cycle.
- Reset at any time forces IDLE, data_out=0, all strobes=0, busy=0, cnt=0, idx=0. An in-flight frame is discarded.

## Timing
- Reset values: data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0.
- Let E0 be the rising edge that first captures serial_in=0 into synchronizer stage 1.
  - START is entered at E0+2.
  - Start sample at E0+2+CLKS_PER_BIT/2.
  - Data bit i is sampled at E0+2+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop sample at E0+2+CLKS_PER_BIT/2+(DATA_W+1)·CLKS_PER_BIT, plus CLKS_PER_BIT when parity is compiled in.
- The result strobe is registered at the stop-sample edge and is high for the following cycle.
- busy goes high at E0+2 and low at the stop-sample edge.
- Back-to-back frames with a stop bit of exactly CLKS_PER_BIT cycles must be received. The stop sample lands at mid-bit, so IDLE is re-entered before the next start edge.

## Configuration
- Macro SERIAL_DESER_PARITY_EN.
- **Defined:** PARITY state present, even parity checked, parity_err driven as described. Frame length is DATA_W+3 bits.
- **Undefined:** no PARITY state, parity_err tied to 0, frame length is DATA_W+2 bits.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_W=8, parity compiled out unless noted.
1. Frame 0xA5 with stop=1 → data_out=0xA5 with data_valid high for exactly one cycle, 154 edges after E0. frame_err=0. busy is high from E0+2 to E0+154.
2. After scenario 1, frame 0x3C with stop=0 → frame_err pulse at E0+154, data_valid stays 0, data_out stays 0xA5.
3. serial_in low for 4 cycles, then high → START entered, glitch rejected at the mid-start sample. No strobes, busy returns to 0, data_out unchanged.
4. Assert rst during data bit 3, release, then send 0x5A → all outputs are 0 while in reset. After release, data_out=0x5A with a single data_valid pulse.
5. Frames 0x00 and 0xFF back-to-back with no idle gap → two data_valid pulses 160 cycles apart, with values 0x00 then 0xFF.
6. With SERIAL_DESER_PARITY_EN defined, send 0x07 with parity bit 0 (correct parity is 1) → parity_err pulse at E0+170, data_valid 0. Resending 0x07 with parity bit 1 → data_out=0x07 with a data_valid pulse.

Source files
------------

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Receive side of the asynchronous serial link. Samples a single-bit line
// framed as: start bit (0), DATA_W data bits LSB first, an optional even
// parity bit, and a stop bit (1). Each correctly framed word is presented on
// data_out together with a one-cycle data_valid strobe. A bad stop bit gives a
// one-cycle frame_err strobe instead, and a parity mismatch gives a one-cycle
// parity_err strobe. In both error cases data_out keeps the previous good word.
//
// Build option:
//   SERIAL_DESER_PARITY_EN  - when defined, the frame carries an even-parity
//                             bit between the data and the stop bit, and
//                             parity_err is driven. When undefined, the parity
//                             bit is absent and parity_err is tied to 0.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (even, >= 4)
//   DATA_W       - data bits per frame (1..16)
//
// Ports:
//   clk        - system clock, all flops on the rising edge
//   rst        - asynchronous active-low reset (0 = reset)
//   serial_in  - asynchronous serial line, idles high
//   data_out   - last correctly framed word, held until the next good frame
//   data_valid - one-cycle pulse when data_out is updated
//   frame_err  - one-cycle pulse when the stop bit is sampled as 0
//   parity_err - one-cycle pulse on parity mismatch (0 without parity)
//   busy       - high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_deserializer #(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    // Sample points: mid start bit, then one full bit period per later bit.
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef SERIAL_DESER_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // State after the last data bit depends on whether a parity bit follows.
`ifdef SERIAL_DESER_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

`ifdef SERIAL_DESER_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the data bits so
    // that the total count of ones over data plus parity is even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic              sync1_q;
    logic              sync2_q;    // synchronized line, "s"
    logic              sd_q;       // one-cycle delayed copy of s, "s_d"
    logic              start_edge_s;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W:0]   shift_cat_s;

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
    logic              par_mis_s;

`ifdef SERIAL_DESER_PARITY_EN
    logic              par_mis_q, par_mis_d;
    logic              perr_q, perr_d;
`endif

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    // Two-flop synchronizer plus delayed copy; all reset high so that leaving
    // reset with an idle line cannot look like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sd_q    <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            sd_q    <= sync2_q;
        end
    end

    // A frame only starts on a high-to-low transition, so a line stuck low
    // never retriggers the receiver.
    assign start_edge_s = sd_q & ~sync2_q;

    // New sample enters at the MSB; after DATA_W samples the LSB-first
    // serial order lands in natural bit order.
    assign shift_cat_s = {sync2_q, shreg_q};

`ifdef SERIAL_DESER_PARITY_EN
    assign par_mis_s = par_mis_q;
`else
    assign par_mis_s = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Receive FSM next-state logic
    // -------------------------------------------------------------------------
    // Next-state, counters, shift register and result strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        par_mis_d = par_mis_q;
        perr_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!sync2_q) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_ZERO;
                        idx_d   = IDX_ZERO;
`ifdef SERIAL_DESER_PARITY_EN
                        par_mis_d = 1'b0;
`endif
                    end else begin
                        // Line back high at mid start bit: glitch, drop it.
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    shreg_d = shift_cat_s[DATA_W:1];
                    idx_d   = idx_q + IDX_ONE;
                    cnt_d   = CNT_ZERO;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef SERIAL_DESER_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    par_mis_d = (sync2_q != even_parity(shreg_q));
                    cnt_d     = CNT_ZERO;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    // Framing error wins over a parity mismatch.
                    if (!sync2_q) begin
                        ferr_d = 1'b1;
                    end else if (par_mis_s) begin
`ifdef SERIAL_DESER_PARITY_EN
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // FSM state, counters and registered outputs; reset discards any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            shreg_q <= {DATA_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SERIAL_DESER_PARITY_EN
    // Parity mismatch flag and parity error strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_mis_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_mis_q <= par_mis_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
